// File: rtl/alu_share_arbiter_if.sv
// Request, shared-ALU and response signals between requesters and the ALU share arbiter.
// The arbiter takes the slave side; requesters, the ALU and the response consumer take the master side.
interface alu_share_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned XLEN    = 32
);
  localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]      req_valid;
  logic [4*NUM_REQ-1:0]    req_op;
  logic [XLEN*NUM_REQ-1:0] req_a;
  logic [XLEN*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]      req_ready;
  logic [3:0]              alu_op;
  logic [XLEN-1:0]         alu_a;
  logic [XLEN-1:0]         alu_b;
  logic [XLEN-1:0]         alu_result;
  logic                    rsp_valid;
  logic [IDW-1:0]          rsp_id;
  logic [XLEN-1:0]         rsp_result;
  logic                    rsp_ready;

  modport master (
    output req_valid, req_op, req_a, req_b, alu_result, rsp_ready,
    input  req_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_id, rsp_result
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, alu_result, rsp_ready,
    output req_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_id, rsp_result
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NUM_REQ requesters,
// with a one-deep response register tagged by the winning requester's ID.
module alu_share_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned XLEN    = 32
) (
  input logic               clk,
  input logic               rst,
  alu_share_arbiter_if.slave bus
);
  localparam int unsigned IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0]  ALU_ADD = 4'h0;

  typedef enum logic {StEmpty, StFull} state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_next;
  logic [IDW-1:0]     rsp_id_q;
  logic [XLEN-1:0]    rsp_result_q;
  logic [IDW-1:0]     winner;
  logic               any_valid;
  logic               can_accept;
  logic               accept;
  logic [NUM_REQ-1:0] grant;

  // Search starts at rr_ptr and wraps; first valid requester wins.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    winner    = '0;
    any_valid = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rr_ptr_q) + k) % NUM_REQ;
      if (!any_valid && bus.req_valid[idx]) begin
        any_valid = 1'b1;
        winner    = IDW'(idx);
      end
    end
  end

  always_comb begin
    grant      = any_valid ? (NUM_REQ'(1) << winner) : '0;
    can_accept = (state_q == StEmpty) || bus.rsp_ready;
    accept     = any_valid && can_accept && !rst;
    rr_next    = IDW'((32'(winner) + 1) % NUM_REQ);
  end

  assign bus.req_ready = grant & {NUM_REQ{can_accept && !rst}};

  always_comb begin
    bus.alu_op = ALU_ADD;
    bus.alu_a  = '0;
    bus.alu_b  = '0;
    if (any_valid) begin
      bus.alu_op = bus.req_op[32'(winner)*4 +: 4];
      bus.alu_a  = bus.req_a[32'(winner)*XLEN +: XLEN];
      bus.alu_b  = bus.req_b[32'(winner)*XLEN +: XLEN];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // A drain in the same cycle as an accept keeps the register full.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (accept) state_d = StFull;
      StFull:  if (bus.rsp_ready && !accept) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  always_comb begin
    bus.rsp_valid  = (state_q == StFull);
    bus.rsp_id     = rsp_id_q;
    bus.rsp_result = rsp_result_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
    end else if (accept) begin
      rr_ptr_q     <= rr_next;
      rsp_id_q     <= winner;
      rsp_result_q <= bus.alu_result;
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU on the shared bus.
module tb_alu_share_arbiter;
  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned XLEN    = 32;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_SLL  = 4'h2;
  localparam logic [3:0] OP_SLT  = 4'h3;
  localparam logic [3:0] OP_SLTU = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SRL  = 4'h6;
  localparam logic [3:0] OP_SRA  = 4'h7;
  localparam logic [3:0] OP_OR   = 4'h8;
  localparam logic [3:0] OP_AND  = 4'h9;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  alu_share_arbiter_if #(.NUM_REQ(NUM_REQ), .XLEN(XLEN)) bus ();

  alu_share_arbiter #(.NUM_REQ(NUM_REQ), .XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always_comb begin
    bus.alu_result = '0;
    case (bus.alu_op)
      OP_ADD:  bus.alu_result = bus.alu_a + bus.alu_b;
      OP_SUB:  bus.alu_result = bus.alu_a - bus.alu_b;
      OP_SLL:  bus.alu_result = bus.alu_a << bus.alu_b[4:0];
      OP_SLT:  bus.alu_result = {31'b0, $signed(bus.alu_a) < $signed(bus.alu_b)};
      OP_SLTU: bus.alu_result = {31'b0, bus.alu_a < bus.alu_b};
      OP_XOR:  bus.alu_result = bus.alu_a ^ bus.alu_b;
      OP_SRL:  bus.alu_result = bus.alu_a >> bus.alu_b[4:0];
      OP_SRA:  bus.alu_result = $unsigned($signed(bus.alu_a) >>> bus.alu_b[4:0]);
      OP_OR:   bus.alu_result = bus.alu_a | bus.alu_b;
      OP_AND:  bus.alu_result = bus.alu_a & bus.alu_b;
      default: bus.alu_result = '0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    bus.req_valid[i]      = v;
    bus.req_op[4*i +: 4]  = op;
    bus.req_a[32*i +: 32] = a;
    bus.req_b[32*i +: 32] = b;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_rsp(input string tag, input logic v, input logic id, input logic [31:0] r);
    check({tag, "_valid"}, 64'(bus.rsp_valid), 64'(v));
    check({tag, "_id"}, 64'(bus.rsp_id), 64'(id));
    check({tag, "_result"}, 64'(bus.rsp_result), 64'(r));
  endtask

  initial begin
    logic exp_id;
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    #1;
    check_rsp("reset", 1'b0, 1'b0, 32'd0);
    check("reset_ready", 64'(bus.req_ready), 64'd0);
    tick;
    tick;
    rst = 1'b0;

    // Test 1: reset while a response is held
    set_req(0, 1'b1, OP_ADD, 32'd100, 32'd100);
    #1;
    check("t1_ready", 64'(bus.req_ready), 64'd1);
    tick;
    check_rsp("t1_first", 1'b1, 1'b0, 32'd200);
    rst = 1'b1;
    #1;
    check_rsp("t1_in_reset", 1'b0, 1'b0, 32'd0);
    check("t1_ready_in_reset", 64'(bus.req_ready), 64'd0);
    tick;
    rst = 1'b0;
    #1;
    check("t1_ready_post", 64'(bus.req_ready), 64'd1);
    tick;
    check_rsp("t1_post", 1'b1, 1'b0, 32'd200);

    // Test 2: contention, pointer now at 1 so grants go 1,0,1,0
    bus.rsp_ready = 1'b1;
    set_req(0, 1'b1, OP_SUB, 32'd100, 32'hFFFF_FF9C);
    set_req(1, 1'b1, OP_SLL, 32'd100, 32'd4);
    for (int k = 0; k < 4; k++) begin
      exp_id = (k % 2 == 0);
      #1;
      check("t2_ready", 64'(bus.req_ready), exp_id ? 64'd2 : 64'd1);
      check("t2_alu_op", 64'(bus.alu_op), exp_id ? 64'(OP_SLL) : 64'(OP_SUB));
      tick;
      check_rsp("t2_rsp", 1'b1, exp_id, exp_id ? 32'd1600 : 32'd200);
    end

    // Test 3: backpressure holds response and blocks grants
    bus.rsp_ready = 1'b0;
    set_req(0, 1'b0, OP_ADD, 32'd0, 32'd0);
    set_req(1, 1'b1, OP_SLTU, 32'hFFFF_FFFF, 32'd0);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t3_ready_blocked", 64'(bus.req_ready), 64'd0);
      check_rsp("t3_hold", 1'b1, 1'b0, 32'd200);
      tick;
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("t3_ready_release", 64'(bus.req_ready), 64'd2);
    tick;
    check_rsp("t3_rsp", 1'b1, 1'b1, 32'd0);

    // Test 4: back-to-back from one requester
    set_req(1, 1'b1, OP_SRA, 32'hFFFF_FF9C, 32'd1);
    #1;
    check("t4_ready_a", 64'(bus.req_ready), 64'd2);
    tick;
    check_rsp("t4_sra", 1'b1, 1'b1, 32'hFFFF_FFCE);
    set_req(1, 1'b1, OP_XOR, 32'd3, 32'd7);
    #1;
    check("t4_ready_b", 64'(bus.req_ready), 64'd2);
    tick;
    check_rsp("t4_xor", 1'b1, 1'b1, 32'd4);

    // Test 5: pointer preserved across idle cycles
    set_req(1, 1'b0, OP_ADD, 32'd0, 32'd0);
    tick;
    check_rsp("t5_drain", 1'b0, 1'b1, 32'd4);
    set_req(0, 1'b1, OP_ADD, 32'd1, 32'd2);
    #1;
    check("t5_ready_req0", 64'(bus.req_ready), 64'd1);
    tick;
    check_rsp("t5_req0", 1'b1, 1'b0, 32'd3);
    set_req(0, 1'b0, OP_ADD, 32'd0, 32'd0);
    tick;
    check("t5_idle_valid", 64'(bus.rsp_valid), 64'd0);
    tick;
    tick;
    set_req(0, 1'b1, OP_ADD, 32'd1, 32'd1);
    set_req(1, 1'b1, OP_ADD, 32'd5, 32'd5);
    #1;
    check("t5_ready_both", 64'(bus.req_ready), 64'd2);
    tick;
    check_rsp("t5_req1", 1'b1, 1'b1, 32'd10);

    // Test 6: quiet bus when nobody requests
    set_req(0, 1'b0, OP_SUB, 32'd9, 32'd9);
    set_req(1, 1'b0, OP_XOR, 32'd9, 32'd9);
    #1;
    check("t6_alu_op", 64'(bus.alu_op), 64'(OP_ADD));
    check("t6_alu_a", 64'(bus.alu_a), 64'd0);
    check("t6_alu_b", 64'(bus.alu_b), 64'd0);
    check("t6_ready", 64'(bus.req_ready), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
